// File: rtl/dp_pkg.sv
// Shared definitions for the execution datapath: ALU opcodes and the
// memory-clear FSM encoding.
package dp_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_LT   = 4'hB;
  localparam logic [3:0] OP_EQ   = 4'hC;
  localparam logic [3:0] OP_PASA = 4'hD;
  localparam logic [3:0] OP_PASB = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (a, b, opcode) -> (y, carry). Carry reports
// carry-out for ADD/INC and borrow for SUB/DEC; it is 0 for every other op.
module alu_core
  import dp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   opcode,
  output logic [W-1:0] y,
  output logic         carry
);

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W:0]     inc;
  logic [W:0]     dec;
  logic [2*W-1:0] prod;

  // One extra bit on each arithmetic path holds the carry/borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign inc  = {1'b0, a} + {{W{1'b0}}, 1'b1};
  assign dec  = {1'b0, a} - {{W{1'b0}}, 1'b1};
  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (opcode)
      OP_ADD:  begin y = sum[W-1:0];  carry = sum[W];  end
      OP_SUB:  begin y = diff[W-1:0]; carry = diff[W]; end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_SHL:  y = a << b[2:0];
      OP_SHR:  y = a >> b[2:0];
      OP_INC:  begin y = inc[W-1:0];  carry = inc[W];  end
      OP_DEC:  begin y = dec[W-1:0];  carry = dec[W];  end
      OP_MUL:  y = prod[W-1:0];
      OP_LT:   y = {{(W-1){1'b0}}, (a < b)};
      OP_EQ:   y = {{(W-1){1'b0}}, (a == b)};
      OP_PASA: y = a;
      OP_PASB: y = b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/exec_datapath.sv
// Execution datapath: ALU, synchronous data memory and result mux driven by
// the control unit on fixed latencies. Optional macro DP_WRITE_FWD_EN.
module exec_datapath
  import dp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry,
  output logic                  ready,
  output state_t                state_dbg
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  state_t                 state;
  state_t                 state_n;
  logic                   clearing;
  logic [ADDR_BITS-1:0]   clr_addr;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  alu_q;
  logic [DATA_WIDTH-1:0]  mem_q;
  logic [DATA_WIDTH-1:0]  alu_b;
  logic [DATA_WIDTH-1:0]  alu_y;
  logic                   alu_c;
  logic [ADDR_BITS-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]  rd_data;

  // There is no handshake with the CU: ready=1 only says the memory clear
  // sweep has finished; after that every input is consumed on every edge.

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_CLEAR: if (clr_addr == LAST_ADDR) state_n = ST_RUN;
      ST_RUN:   state_n = ST_RUN;
      default:  state_n = ST_CLEAR;
    endcase
  end

  always_comb begin
    clearing  = (state == ST_CLEAR);
    ready     = (state == ST_RUN);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (rst)           clr_addr <= '0;
    else if (clearing) clr_addr <= clr_addr + 1'b1;
  end

  assign alu_b = sel3 ? offset : operand2;

  alu_core #(.W(DATA_WIDTH)) u_alu (
    .a      (operand1),
    .b      (alu_b),
    .opcode (opcode),
    .y      (alu_y),
    .carry  (alu_c)
  );

  // Memory is addressed by the registered ALU result; upper bits wrap away.
  assign mem_addr = alu_q[ADDR_BITS-1:0];

`ifdef DP_WRITE_FWD_EN
  assign rd_data = w_r ? operand2 : mem[mem_addr];
`else
  assign rd_data = mem[mem_addr];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing)  mem[clr_addr] <= '0;
      else if (w_r)  mem[mem_addr] <= operand2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clearing) begin
      alu_q <= '0;
      mem_q <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else begin
      mem_q <= rd_data;
      if (opcode != OP_NOP) begin
        alu_q <= alu_y;
        zero  <= (alu_y == '0);
        carry <= alu_c;
      end
    end
  end

  assign result2 = sel1 ? alu_q : mem_q;

endmodule
